// File: rtl/mem_port_arbiter.sv
// Serialises IF and MA accesses of the RV32IM core onto one memory port and stalls the core until both finish.
// Optional one-entry instruction buffer: define ARB_INST_BUFFER_EN.
module mem_port_arbiter #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] PC_IF,
    output logic [31:0]       INST_IF,
    input  logic [ADDR_W-1:0] DMEM_ADDR_MA,
    input  logic [31:0]       DMEM_DATA_WRITE_MA,
    input  logic [3:0]        DMEM_READ_MA,
    input  logic [2:0]        DMEM_WRITE_MA,
    output logic [31:0]       DMEM_DATA_READ_MA,
    output logic              BUSYWAIT,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_WDATA,
    output logic [3:0]        MEM_READ,
    output logic [2:0]        MEM_WRITE,
    input  logic [31:0]       MEM_RDATA,
    input  logic              MEM_BUSYWAIT
);

    localparam logic [3:0] FETCH_CMD = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        D_ACC,
        I_ACC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_read;
    logic [2:0]        req_write;

    logic mem_done;
    logic new_data_req;
    logic fetch_hit;
    logic fetch_needed;

    assign mem_done     = ~MEM_BUSYWAIT;
    assign new_data_req = DMEM_READ_MA[3] | DMEM_WRITE_MA[2];
    assign BUSYWAIT     = (state != DONE);

`ifdef ARB_INST_BUFFER_EN
    logic              buf_valid;
    logic              skip_fetch;
    logic [ADDR_W-1:0] buf_tag;
    logic              buf_inval;

    assign fetch_hit = buf_valid && (PC_IF == buf_tag);
    assign buf_inval = req_write[2] && (req_addr[ADDR_W-1:2] == buf_tag[ADDR_W-1:2]);
    // A store that overwrites the buffered word in this same step forces the fetch back on.
    assign fetch_needed = ~skip_fetch | (buf_valid & buf_inval);

    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_valid  <= 1'b0;
            skip_fetch <= 1'b0;
            buf_tag    <= '0;
        end else begin
            case (state)
                IDLE:  skip_fetch <= fetch_hit;
                D_ACC: if (mem_done && buf_inval) buf_valid <= 1'b0;
                I_ACC: if (mem_done) begin
                    buf_valid <= 1'b1;
                    buf_tag   <= req_pc;
                end
                default: ;
            endcase
        end
    end
`else
    assign fetch_hit    = 1'b0;
    assign fetch_needed = 1'b1;
`endif

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        state_next = state;
        MEM_ADDR   = '0;
        MEM_WDATA  = '0;
        MEM_READ   = '0;
        MEM_WRITE  = '0;
        case (state)
            IDLE: begin
                if (new_data_req)   state_next = D_ACC;
                else if (fetch_hit) state_next = DONE;
                else                state_next = I_ACC;
            end
            D_ACC: begin
                MEM_ADDR  = req_addr;
                MEM_WDATA = req_wdata;
                MEM_WRITE = req_write;
                // When both enables are set only the write goes out.
                MEM_READ  = req_write[2] ? 4'b0000 : req_read;
                if (mem_done) state_next = fetch_needed ? I_ACC : DONE;
            end
            I_ACC: begin
                MEM_ADDR = req_pc;
                MEM_READ = FETCH_CMD;
                if (mem_done) state_next = DONE;
            end
            DONE: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (RST) begin
            state             <= IDLE;
            INST_IF           <= NOP_INST;
            DMEM_DATA_READ_MA <= '0;
            req_pc            <= '0;
            req_addr          <= '0;
            req_wdata         <= '0;
            req_read          <= '0;
            req_write         <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    req_pc    <= PC_IF;
                    req_addr  <= DMEM_ADDR_MA;
                    req_wdata <= DMEM_DATA_WRITE_MA;
                    req_read  <= DMEM_READ_MA;
                    req_write <= DMEM_WRITE_MA;
                end
                D_ACC: if (mem_done) DMEM_DATA_READ_MA <= req_write[2] ? 32'h0 : MEM_RDATA;
                I_ACC: if (mem_done) INST_IF <= MEM_RDATA;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model with programmable wait states and an access scoreboard.
module tb_mem_port_arbiter;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] PC_IF = '0;
    logic [31:0] INST_IF;
    logic [31:0] DMEM_ADDR_MA = '0;
    logic [31:0] DMEM_DATA_WRITE_MA = '0;
    logic [3:0]  DMEM_READ_MA = '0;
    logic [2:0]  DMEM_WRITE_MA = '0;
    logic [31:0] DMEM_DATA_READ_MA;
    logic        BUSYWAIT;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_READ;
    logic [2:0]  MEM_WRITE;
    logic [31:0] MEM_RDATA;
    logic        MEM_BUSYWAIT = 1'b0;

    mem_port_arbiter dut (
        .CLK(CLK), .RST(RST),
        .PC_IF(PC_IF), .INST_IF(INST_IF),
        .DMEM_ADDR_MA(DMEM_ADDR_MA), .DMEM_DATA_WRITE_MA(DMEM_DATA_WRITE_MA),
        .DMEM_READ_MA(DMEM_READ_MA), .DMEM_WRITE_MA(DMEM_WRITE_MA),
        .DMEM_DATA_READ_MA(DMEM_DATA_READ_MA), .BUSYWAIT(BUSYWAIT),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_RDATA(MEM_RDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:1023];
    assign MEM_RDATA = mem[MEM_ADDR[11:2]];

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rcmd;
        logic [2:0]  wcmd;
    } acc_t;

    acc_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wait_rd = 0;
    int   wait_wr = 0;
    int   elapsed = 0;
    bit   prev_busy = 1'b0;
    logic [31:0] held_addr, held_wdata;
    logic [3:0]  held_read;
    logic [2:0]  held_write;

    function automatic logic [31:0] inst_at(input logic [31:0] pc);
        return 32'h1000_0000 | (pc >> 2);
    endfunction

    // Memory side: decides MEM_BUSYWAIT each negedge, checks stability while stalled,
    // and scores every completing access against the expected queue.
    task automatic memory_model();
        acc_t e;
        bit   active;
        int   cfg;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_busy    = 1'b0;
                elapsed      = 0;
                MEM_BUSYWAIT = 1'b0;
            end else begin
                if (prev_busy) begin
                    checks++;
                    if ({MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE} !== {held_addr, held_wdata, held_read, held_write}) begin
                        errors++;
                        $display("FAIL cmd_stable: got addr=%h wdata=%h rd=%b wr=%b, required addr=%h wdata=%h rd=%b wr=%b",
                                 MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE, held_addr, held_wdata, held_read, held_write);
                    end
                end
                active       = MEM_READ[3] | MEM_WRITE[2];
                cfg          = MEM_WRITE[2] ? wait_wr : wait_rd;
                MEM_BUSYWAIT = active && (elapsed < cfg);
                prev_busy    = MEM_BUSYWAIT;
                held_addr    = MEM_ADDR;
                held_wdata   = MEM_WDATA;
                held_read    = MEM_READ;
                held_write   = MEM_WRITE;
                if (!active) begin
                    elapsed = 0;
                end else if (MEM_BUSYWAIT) begin
                    elapsed++;
                end else begin
                    elapsed = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL access_order: got addr=%h rd=%b wr=%b, required no access", MEM_ADDR, MEM_READ, MEM_WRITE);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_write) begin
                            if ({MEM_ADDR, MEM_WDATA, MEM_WRITE, MEM_READ[3]} !== {e.addr, e.wdata, e.wcmd, 1'b0}) begin
                                errors++;
                                $display("FAIL access_write: got addr=%h wdata=%h wr=%b rd=%b, required addr=%h wdata=%h wr=%b rd_en=0",
                                         MEM_ADDR, MEM_WDATA, MEM_WRITE, MEM_READ, e.addr, e.wdata, e.wcmd);
                            end
                        end else if ({MEM_ADDR, MEM_READ, MEM_WRITE[2]} !== {e.addr, e.rcmd, 1'b0}) begin
                            errors++;
                            $display("FAIL access_read: got addr=%h rd=%b wr=%b, required addr=%h rd=%b wr_en=0",
                                     MEM_ADDR, MEM_READ, MEM_WRITE, e.addr, e.rcmd);
                        end
                    end
                    if (MEM_WRITE[2]) mem[MEM_ADDR[11:2]] = MEM_WDATA;
                end
            end
        end
    endtask

    // Counts cycles from the IDLE cycle through the DONE cycle (BUSYWAIT low), bounded.
    task automatic wait_done(output int cycles);
        cycles = 1;
        while (BUSYWAIT !== 1'b0 && cycles < 100) begin
            @(negedge CLK);
            cycles++;
        end
    endtask

    // Called at a negedge while the DUT is in IDLE; returns in the DONE cycle.
    task automatic run_step(input logic [31:0] pc, input logic [3:0] rd, input logic [2:0] wr,
                            input logic [31:0] addr, input logic [31:0] wdata, input bit fetch,
                            output int cycles);
        PC_IF              = pc;
        DMEM_READ_MA       = rd;
        DMEM_WRITE_MA      = wr;
        DMEM_ADDR_MA       = addr;
        DMEM_DATA_WRITE_MA = wdata;
        if (wr[2])      exp_q.push_back('{1'b1, addr, wdata, 4'b0000, wr});
        else if (rd[3]) exp_q.push_back('{1'b0, addr, 32'h0, rd, 3'b000});
        if (fetch)      exp_q.push_back('{1'b0, pc, 32'h0, 4'b1010, 3'b000});
        wait_done(cycles);
    endtask

    task automatic next_cycle();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (INST_IF !== NOP) begin errors++; $display("FAIL reset_inst: got %h, required %h", INST_IF, NOP); end
        checks++;
        if (DMEM_DATA_READ_MA !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, required 0", DMEM_DATA_READ_MA); end
        checks++;
        if ({MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE} !== '0) begin
            errors++; $display("FAIL reset_mem: got addr=%h wdata=%h rd=%b wr=%b, required all 0", MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE);
        end
        checks++;
        if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, required 1", BUSYWAIT); end
        RST = 1'b0;
    endtask

    task automatic test_fetch();
        int cyc;
        run_step(32'h0, 4'b0, 3'b0, 32'h0, 32'h0, 1'b1, cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL fetch_cycles: got %0d, required 3", cyc); end
        checks++;
        if (INST_IF !== 32'h0050_0093) begin errors++; $display("FAIL fetch_inst: got %h, required 00500093", INST_IF); end
        next_cycle();
        checks++;
        if ({MEM_READ, MEM_WRITE} !== 7'b0) begin errors++; $display("FAIL idle_cmd: got rd=%b wr=%b, required 0", MEM_READ, MEM_WRITE); end
    endtask

    task automatic test_load();
        int cyc;
        run_step(32'h4, 4'b1010, 3'b000, 32'h100, 32'h0, 1'b1, cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL load_cycles: got %0d, required 4", cyc); end
        checks++;
        if (DMEM_DATA_READ_MA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h, required deadbeef", DMEM_DATA_READ_MA); end
        checks++;
        if (INST_IF !== inst_at(32'h4)) begin errors++; $display("FAIL load_inst: got %h, required %h", INST_IF, inst_at(32'h4)); end
        next_cycle();
        run_step(32'h18, 4'b1100, 3'b011, 32'h104, 32'h0, 1'b1, cyc);
        checks++;
        if (DMEM_DATA_READ_MA !== 32'h8070_6050) begin errors++; $display("FAIL lbu_data: got %h, required 80706050", DMEM_DATA_READ_MA); end
        next_cycle();
    endtask

    task automatic test_store_wait();
        int cyc;
        wait_wr = 3;
        run_step(32'hC, 4'b0, 3'b110, 32'h200, 32'h1234_5678, 1'b1, cyc);
        checks++;
        if (cyc !== 7) begin errors++; $display("FAIL store_cycles: got %0d, required 7", cyc); end
        checks++;
        if (mem[10'h80] !== 32'h1234_5678) begin errors++; $display("FAIL store_mem: got %h, required 12345678", mem[10'h80]); end
        checks++;
        if (DMEM_DATA_READ_MA !== 32'h0) begin errors++; $display("FAIL store_data: got %h, required 0", DMEM_DATA_READ_MA); end
        checks++;
        if (INST_IF !== inst_at(32'hC)) begin errors++; $display("FAIL store_inst: got %h, required %h", INST_IF, inst_at(32'hC)); end
        wait_wr = 0;
        next_cycle();
    endtask

    task automatic test_read_wait();
        int cyc;
        wait_rd = 2;
        run_step(32'h1C, 4'b0, 3'b0, 32'h0, 32'h0, 1'b1, cyc);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL fetch_wait_cycles: got %0d, required 5", cyc); end
        checks++;
        if (DMEM_DATA_READ_MA !== 32'h0) begin errors++; $display("FAIL data_hold: got %h, required 0", DMEM_DATA_READ_MA); end
        wait_rd = 0;
        next_cycle();
    endtask

    task automatic test_both_enables();
        int cyc;
        run_step(32'h20, 4'b1010, 3'b000, 32'h100, 32'h0, 1'b1, cyc);
        next_cycle();
        run_step(32'h24, 4'b1010, 3'b110, 32'h300, 32'hCAFE_F00D, 1'b1, cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL both_cycles: got %0d, required 4", cyc); end
        checks++;
        if (DMEM_DATA_READ_MA !== 32'h0) begin errors++; $display("FAIL both_data: got %h, required 0", DMEM_DATA_READ_MA); end
        checks++;
        if (mem[10'hC0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL both_mem: got %h, required cafef00d", mem[10'hC0]); end
        next_cycle();
    endtask

    task automatic test_ignore_busy();
        int cyc;
        PC_IF = 32'h14; DMEM_READ_MA = 4'b1010; DMEM_WRITE_MA = 3'b000;
        DMEM_ADDR_MA = 32'h108; DMEM_DATA_WRITE_MA = 32'h0;
        exp_q.push_back('{1'b0, 32'h108, 32'h0, 4'b1010, 3'b000});
        exp_q.push_back('{1'b0, 32'h14, 32'h0, 4'b1010, 3'b000});
        next_cycle();
        PC_IF = 32'h40; DMEM_READ_MA = 4'b0; DMEM_WRITE_MA = 3'b110;
        DMEM_ADDR_MA = 32'h340; DMEM_DATA_WRITE_MA = 32'hFFFF_FFFF;
        wait_done(cyc);
        cyc++;
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL ignore_cycles: got %0d, required 4", cyc); end
        checks++;
        if ({INST_IF, DMEM_DATA_READ_MA} !== {inst_at(32'h14), 32'h55AA_33CC}) begin
            errors++; $display("FAIL ignore_result: got inst=%h data=%h, required inst=%h data=55aa33cc", INST_IF, DMEM_DATA_READ_MA, inst_at(32'h14));
        end
        checks++;
        if (mem[10'hD0] !== 32'h0) begin errors++; $display("FAIL ignore_mem: got %h, required 0", mem[10'hD0]); end
        next_cycle();
    endtask

    task automatic test_reset_abort();
        int cyc;
        wait_rd = 5;
        PC_IF = 32'h10; DMEM_READ_MA = 4'b0; DMEM_WRITE_MA = 3'b0;
        next_cycle();
        checks++;
        if ({MEM_READ, MEM_ADDR} !== {4'b1010, 32'h10}) begin errors++; $display("FAIL abort_fetch: got rd=%b addr=%h, required rd=1010 addr=10", MEM_READ, MEM_ADDR); end
        RST = 1'b1;
        next_cycle();
        checks++;
        if ({MEM_READ, MEM_WRITE} !== 7'b0) begin errors++; $display("FAIL abort_cmd: got rd=%b wr=%b, required 0", MEM_READ, MEM_WRITE); end
        checks++;
        if ({INST_IF, DMEM_DATA_READ_MA} !== {NOP, 32'h0}) begin
            errors++; $display("FAIL abort_regs: got inst=%h data=%h, required inst=%h data=0", INST_IF, DMEM_DATA_READ_MA, NOP);
        end
        checks++;
        if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b, required 1", BUSYWAIT); end
        RST = 1'b0;
        wait_rd = 0;
        run_step(32'h0, 4'b0, 3'b0, 32'h0, 32'h0, 1'b1, cyc);
        checks++;
        if ({cyc, INST_IF} !== {32'd3, 32'h0050_0093}) begin
            errors++; $display("FAIL abort_restart: got cycles=%0d inst=%h, required cycles=3 inst=00500093", cyc, INST_IF);
        end
        next_cycle();
    endtask

    task automatic test_inst_buffer();
        int cyc;
        bit buffered;
        int hit_cycles;
`ifdef ARB_INST_BUFFER_EN
        buffered = 1'b1;
`else
        buffered = 1'b0;
`endif
        hit_cycles = buffered ? 2 : 3;
        run_step(32'h8, 4'b0, 3'b0, 32'h0, 32'h0, 1'b1, cyc);
        checks++;
        if ({cyc, INST_IF} !== {32'd3, inst_at(32'h8)}) begin
            errors++; $display("FAIL buf_first: got cycles=%0d inst=%h, required cycles=3 inst=%h", cyc, INST_IF, inst_at(32'h8));
        end
        next_cycle();
        run_step(32'h8, 4'b0, 3'b0, 32'h0, 32'h0, !buffered, cyc);
        checks++;
        if ({cyc, INST_IF} !== {hit_cycles, inst_at(32'h8)}) begin
            errors++; $display("FAIL buf_repeat: got cycles=%0d inst=%h, required cycles=%0d inst=%h", cyc, INST_IF, hit_cycles, inst_at(32'h8));
        end
        next_cycle();
        run_step(32'h8, 4'b0, 3'b110, 32'h8, 32'h00A0_0513, 1'b1, cyc);
        checks++;
        if ({cyc, INST_IF} !== {32'd4, 32'h00A0_0513}) begin
            errors++; $display("FAIL buf_invalidate: got cycles=%0d inst=%h, required cycles=4 inst=00a00513", cyc, INST_IF);
        end
        next_cycle();
        run_step(32'h8, 4'b0, 3'b0, 32'h0, 32'h0, !buffered, cyc);
        checks++;
        if ({cyc, INST_IF} !== {hit_cycles, 32'h00A0_0513}) begin
            errors++; $display("FAIL buf_refill: got cycles=%0d inst=%h, required cycles=%0d inst=00a00513", cyc, INST_IF, hit_cycles);
        end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = (i < 64) ? (32'h1000_0000 | 32'(i)) : 32'h0;
        mem[0]     = 32'h0050_0093;
        mem[10'h40] = 32'hDEAD_BEEF;
        mem[10'h41] = 32'h8070_6050;
        mem[10'h42] = 32'h55AA_33CC;
        fork
            memory_model();
        join_none
        test_reset();
        test_fetch();
        test_load();
        test_store_wait();
        test_read_wait();
        test_both_enables();
        test_ignore_busy();
        test_reset_abort();
        test_inst_buffer();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
